// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave memory endpoint.
package i2c_pkg;

  // FSM state encoding; also exported on the debug state port.
  typedef logic [3:0] i2c_slave_state_t;

  localparam i2c_slave_state_t StIdle     = 4'd0;
  localparam i2c_slave_state_t StDev      = 4'd1;
  localparam i2c_slave_state_t StDevAck   = 4'd2;
  localparam i2c_slave_state_t StMaddr    = 4'd3;
  localparam i2c_slave_state_t StMaddrAck = 4'd4;
  localparam i2c_slave_state_t StWdata    = 4'd5;
  localparam i2c_slave_state_t StWdataAck = 4'd6;
  localparam i2c_slave_state_t StRdata    = 4'd7;
  localparam i2c_slave_state_t StRdataAck = 4'd8;
  localparam i2c_slave_state_t StWaitStop = 4'd9;

  localparam logic I2C_RW_READ = 1'b1;
  localparam logic I2C_ACK     = 1'b0;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus edge, start and stop detection.
module i2c_bus_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;
  logic       scl_s;
  logic       sda_s;

  // Synchronizer chains and previous-cycle copies; idle bus level is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];

  // Single-cycle event pulses derived from the synchronized levels.
  always_comb begin
    sda_o       = sda_s;
    scl_rise_o  = scl_s & ~scl_prev_q;
    scl_fall_o  = ~scl_s & scl_prev_q;
    start_det_o = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    stop_det_o  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  end

endmodule

// File: rtl/i2c_slave_mem.sv
// I2C slave that maps bus frames onto single-cycle memory-port accesses.
// Optional feature macro: I2C_SLAVE_AUTOINC_EN (multi-byte bursts with address
// auto-increment); when undefined only one data byte is accepted per frame.
module i2c_slave_mem
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'b0000001,
  parameter int unsigned MEM_AW   = 6
) (
  input  logic              clk8x,
  input  logic              reset,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              mem_ce,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic [3:0]        state
);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_sync u_bus_sync (
    .clk_i       (clk8x),
    .rst_ni      (reset),
    .scl_i       (scl_i),
    .sda_i       (sda_i),
    .sda_o       (sda_s),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det)
  );

  i2c_slave_state_t  state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        rx_sh_q, rx_sh_d;
  logic [7:0]        tx_sh_q, tx_sh_d;
  logic              rw_q, rw_d;
  // In ACK states: second half pending (driving ACK, or master ACK seen on reads).
  logic              ack_on_q, ack_on_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              mem_ce_q, mem_ce_d;
  logic              mem_rden_q, mem_rden_d;
  logic              mem_wren_q, mem_wren_d;
  logic              rd_load_q, rd_load_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]        rx_byte;

  assign rx_byte = {rx_sh_q, sda_s};

  // Next-state logic: bus events first, then per-state bit/ACK handling.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    rw_d        = rw_q;
    ack_on_d    = ack_on_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_ce_d    = 1'b0;
    mem_rden_d  = 1'b0;
    mem_wren_d  = 1'b0;
    // Read data is valid the cycle after the strobe.
    rd_load_d   = mem_rden_q;
    if (rd_load_q) begin
      tx_sh_d = mem_rdata;
    end

    if (stop_det) begin
      state_d   = StIdle;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 3'd0;
      ack_on_d  = 1'b0;
    end else if (start_det) begin
      state_d   = StDev;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 3'd0;
      ack_on_d  = 1'b0;
    end else begin
      case (state_q)
        StDev, StMaddr, StWdata: begin
          if (scl_rise) begin
            rx_sh_d   = rx_byte[6:0];
            // Wraps to zero on the byte boundary.
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == StDev) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  rw_d    = rx_byte[0];
                  state_d = StDevAck;
                end else begin
                  state_d = StWaitStop;
                end
              end else if (state_q == StMaddr) begin
                mem_addr_d = rx_byte[MEM_AW-1:0];
                state_d    = StMaddrAck;
                if (rw_q == I2C_RW_READ) begin
                  mem_ce_d   = 1'b1;
                  mem_rden_d = 1'b1;
                end
              end else begin
                mem_wdata_d = rx_byte;
                state_d     = StWdataAck;
              end
            end
          end
        end

        StDevAck, StMaddrAck, StWdataAck: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              ack_on_d = 1'b1;
              sda_oe_d = 1'b1;
              if (state_q == StDevAck) begin
                busy_d = 1'b1;
              end
              if (state_q == StWdataAck) begin
                mem_ce_d   = 1'b1;
                mem_wren_d = 1'b1;
              end
            end else begin
              ack_on_d = 1'b0;
              sda_oe_d = 1'b0;
              if (state_q == StDevAck) begin
                state_d = StMaddr;
              end else if (state_q == StMaddrAck) begin
                if (rw_q == I2C_RW_READ) begin
                  state_d  = StRdata;
                  sda_oe_d = ~tx_sh_q[7];
                end else begin
                  state_d = StWdata;
                end
              end else begin
`ifdef I2C_SLAVE_AUTOINC_EN
                mem_addr_d = mem_addr_q + MEM_AW'(1);
                state_d    = StWdata;
`else
                state_d    = StWaitStop;
`endif
              end
            end
          end
        end

        StRdata: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = StRdataAck;
            end
          end else if (scl_fall) begin
            tx_sh_d  = {tx_sh_q[6:0], 1'b0};
            sda_oe_d = ~tx_sh_q[6];
          end
        end

        StRdataAck: begin
          if (scl_rise) begin
`ifdef I2C_SLAVE_AUTOINC_EN
            if (sda_s == I2C_ACK) begin
              mem_addr_d = mem_addr_q + MEM_AW'(1);
              mem_ce_d   = 1'b1;
              mem_rden_d = 1'b1;
              ack_on_d   = 1'b1;
            end else begin
              state_d = StWaitStop;
            end
`else
            state_d = StWaitStop;
`endif
          end else if (scl_fall) begin
            if (ack_on_q) begin
              ack_on_d = 1'b0;
              state_d  = StRdata;
              sda_oe_d = ~tx_sh_q[7];
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end

        default: ;
      endcase
    end
  end

  // State registers; async reset releases SDA immediately.
  always_ff @(posedge clk8x or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      rx_sh_q     <= 7'd0;
      tx_sh_q     <= 8'd0;
      rw_q        <= 1'b0;
      ack_on_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_rden_q  <= 1'b0;
      mem_wren_q  <= 1'b0;
      rd_load_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      rw_q        <= rw_d;
      ack_on_q    <= ack_on_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      mem_ce_q    <= mem_ce_d;
      mem_rden_q  <= mem_rden_d;
      mem_wren_q  <= mem_wren_d;
      rd_load_q   <= rd_load_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Registered outputs.
  always_comb begin
    sda_oe    = sda_oe_q;
    mem_ce    = mem_ce_q;
    mem_rden  = mem_rden_q;
    mem_wren  = mem_wren_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    busy      = busy_q;
    state     = state_q;
  end

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Bench for i2c_slave_mem: bit-banged I2C master, memory model and a write/read
// scoreboard. Build with +define+I2C_SLAVE_AUTOINC_EN to cover burst mode.
module tb_i2c_slave_mem;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk;
  logic       rst_n;
  logic       scl_m;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_oe;
  logic       mem_ce;
  logic       mem_rden;
  logic       mem_wren;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;
  logic [3:0] state;

  logic [7:0] mem [64];
  wr_t        wr_q[$];
  logic [7:0] rd_q[$];
  int         n_checks;
  int         n_errors;
  int         n_wren;
  int         n_rden;
  logic       wren_prev;
  logic       rden_prev;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_mem #(
    .DEV_ADDR (7'b0000001),
    .MEM_AW   (6)
  ) dut (
    .clk8x     (clk),
    .reset     (rst_n),
    .scl_i     (scl_m),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .mem_ce    (mem_ce),
    .mem_rden  (mem_rden),
    .mem_wren  (mem_wren),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: synchronous write, read data valid one cycle after rden.
  always @(posedge clk) begin
    if (mem_ce && mem_wren) mem[mem_addr] <= mem_wdata;
    if (mem_ce && mem_rden) mem_rdata <= mem[mem_addr];
  end

  // Strobe monitor and write scoreboard.
  always @(negedge clk) begin
    logic found;
    wr_t  e;
    if (mem_wren) begin
      n_wren <= n_wren + 1;
      check_eq("wren_ce", {31'd0, mem_ce}, 32'd1);
      check_eq("wren_rden_excl", {31'd0, mem_rden}, 32'd0);
      check_eq("wren_width", {31'd0, wren_prev}, 32'd0);
      found = (wr_q.size() != 0);
      check_eq("wr_expected", {31'd0, found}, 32'd1);
      if (found) begin
        e = wr_q.pop_front();
        check_eq("wr_addr", {26'd0, mem_addr}, {26'd0, e.addr});
        check_eq("wr_data", {24'd0, mem_wdata}, {24'd0, e.data});
      end
    end
    if (mem_rden) begin
      n_rden <= n_rden + 1;
      check_eq("rden_ce", {31'd0, mem_ce}, 32'd1);
      check_eq("rden_width", {31'd0, rden_prev}, 32'd0);
    end
    wren_prev <= mem_wren;
    rden_prev <= mem_rden;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    wait_clks(4);
    scl_m = 1'b1;
    wait_clks(8);
    sda_m = 1'b0;
    wait_clks(8);
    scl_m = 1'b0;
    wait_clks(4);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    wait_clks(4);
    scl_m = 1'b1;
    wait_clks(8);
    sda_m = 1'b1;
    wait_clks(8);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;
    wait_clks(4);
    scl_m = 1'b1;
    wait_clks(8);
    scl_m = 1'b0;
    wait_clks(4);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1;
    wait_clks(4);
    scl_m = 1'b1;
    wait_clks(4);
    b = sda_bus;
    wait_clks(4);
    scl_m = 1'b0;
    wait_clks(4);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(ack_n);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic master_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    send_bit(~master_ack);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       ack_n;
    logic [7:0] rd;
    logic [7:0] exp_rd;
    int         wr0;
    int         rd0;

    n_checks  = 0;
    n_errors  = 0;
    n_wren    = 0;
    n_rden    = 0;
    wren_prev = 1'b0;
    rden_prev = 1'b0;
    mem_rdata = 8'h00;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clks(5);

    check_eq("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check_eq("rst_mem_ce", {31'd0, mem_ce}, 32'd0);
    check_eq("rst_mem_rden", {31'd0, mem_rden}, 32'd0);
    check_eq("rst_mem_wren", {31'd0, mem_wren}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
    check_eq("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check_eq("rst_state", {28'd0, state}, 32'd0);
    rst_n = 1'b1;
    wait_clks(10);

    // Write frame: dev 0x01/W, maddr 0x02, data 0xFF.
    wr0 = n_wren;
    bus_start();
    write_byte(8'h02, ack_n);
    check_eq("wr_dev_ack", {31'd0, ack_n}, 32'd0);
    check_eq("wr_busy", {31'd0, busy}, 32'd1);
    write_byte(8'h02, ack_n);
    check_eq("wr_maddr_ack", {31'd0, ack_n}, 32'd0);
    wr_q.push_back('{addr: 6'h02, data: 8'hFF});
    write_byte(8'hFF, ack_n);
    check_eq("wr_data_ack", {31'd0, ack_n}, 32'd0);
    bus_stop();
    wait_clks(4);
    check_eq("wr_idle", {28'd0, state}, 32'd0);
    check_eq("wr_busy_clr", {31'd0, busy}, 32'd0);
    check_eq("wr_count", n_wren - wr0, 32'd1);
    check_eq("wr_sb_empty", wr_q.size(), 32'd0);
    check_eq("wr_mem2", {24'd0, mem[2]}, 32'h0000_00FF);

    // Read frame: dev 0x01/R, maddr 0x02, memory[2] = 0xA5, master NACK.
    mem[2] = 8'hA5;
    wr0 = n_wren;
    rd0 = n_rden;
    bus_start();
    write_byte(8'h03, ack_n);
    check_eq("rd_dev_ack", {31'd0, ack_n}, 32'd0);
    write_byte(8'h02, ack_n);
    check_eq("rd_maddr_ack", {31'd0, ack_n}, 32'd0);
    rd_q.push_back(8'hA5);
    read_byte(rd, 1'b0);
    exp_rd = rd_q.pop_front();
    check_eq("rd_data", {24'd0, rd}, {24'd0, exp_rd});
    check_eq("rd_wait_stop", {28'd0, state}, 32'd9);
    bus_stop();
    wait_clks(4);
    check_eq("rd_idle", {28'd0, state}, 32'd0);
    check_eq("rd_count", n_rden - rd0, 32'd1);
    check_eq("rd_no_write", n_wren - wr0, 32'd0);

    // Wrong device address: no ACK, no strobes, wait for stop.
    wr0 = n_wren;
    rd0 = n_rden;
    bus_start();
    write_byte(8'h0A, ack_n);
    check_eq("nodev_nack", {31'd0, ack_n}, 32'd1);
    check_eq("nodev_wait_stop", {28'd0, state}, 32'd9);
    write_byte(8'h55, ack_n);
    check_eq("nodev_nack2", {31'd0, ack_n}, 32'd1);
    check_eq("nodev_busy", {31'd0, busy}, 32'd0);
    bus_stop();
    wait_clks(4);
    check_eq("nodev_idle", {28'd0, state}, 32'd0);
    check_eq("nodev_strobes", (n_wren - wr0) + (n_rden - rd0), 32'd0);

    // Repeated start after the address ACK, then a read of address 0x02.
    wr0 = n_wren;
    rd0 = n_rden;
    bus_start();
    write_byte(8'h02, ack_n);
    write_byte(8'h02, ack_n);
    check_eq("rs_maddr_ack", {31'd0, ack_n}, 32'd0);
    bus_start();
    check_eq("rs_state_dev", {28'd0, state}, 32'd1);
    check_eq("rs_addr_kept", {26'd0, mem_addr}, 32'd2);
    write_byte(8'h03, ack_n);
    check_eq("rs_dev_ack", {31'd0, ack_n}, 32'd0);
    write_byte(8'h02, ack_n);
    rd_q.push_back(8'hA5);
    read_byte(rd, 1'b0);
    exp_rd = rd_q.pop_front();
    check_eq("rs_rd_data", {24'd0, rd}, {24'd0, exp_rd});
    bus_stop();
    wait_clks(4);
    check_eq("rs_no_write", n_wren - wr0, 32'd0);
    check_eq("rs_rd_count", n_rden - rd0, 32'd1);

    // Stop in the middle of a data byte: no write.
    wr0 = n_wren;
    bus_start();
    write_byte(8'h02, ack_n);
    write_byte(8'h10, ack_n);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus_stop();
    wait_clks(4);
    check_eq("midstop_idle", {28'd0, state}, 32'd0);
    check_eq("midstop_no_write", n_wren - wr0, 32'd0);

    // Reset asserted while the slave is driving the device-address ACK.
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : (i == 1));
    sda_m = 1'b1;
    wait_clks(4);
    scl_m = 1'b1;
    wait_clks(4);
    check_eq("ack_driven", {31'd0, sda_oe}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("reset_release", {31'd0, sda_oe}, 32'd0);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_state", {28'd0, state}, 32'd0);
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(10);

    // Multi-byte write from 0x3F.
    wr0 = n_wren;
    bus_start();
    write_byte(8'h02, ack_n);
    write_byte(8'h3F, ack_n);
    wr_q.push_back('{addr: 6'h3F, data: 8'h11});
`ifdef I2C_SLAVE_AUTOINC_EN
    wr_q.push_back('{addr: 6'h00, data: 8'h22});
    wr_q.push_back('{addr: 6'h01, data: 8'h33});
    write_byte(8'h11, ack_n);
    check_eq("burst_ack0", {31'd0, ack_n}, 32'd0);
    write_byte(8'h22, ack_n);
    check_eq("burst_ack1", {31'd0, ack_n}, 32'd0);
    write_byte(8'h33, ack_n);
    check_eq("burst_ack2", {31'd0, ack_n}, 32'd0);
    bus_stop();
    wait_clks(4);
    check_eq("burst_count", n_wren - wr0, 32'd3);
    check_eq("burst_mem00", {24'd0, mem[0]}, 32'h22);
    check_eq("burst_mem01", {24'd0, mem[1]}, 32'h33);
`else
    write_byte(8'h11, ack_n);
    check_eq("single_ack0", {31'd0, ack_n}, 32'd0);
    write_byte(8'h22, ack_n);
    check_eq("single_nack1", {31'd0, ack_n}, 32'd1);
    bus_stop();
    wait_clks(4);
    check_eq("single_count", n_wren - wr0, 32'd1);
`endif
    check_eq("burst_mem3f", {24'd0, mem[63]}, 32'h11);
    check_eq("burst_sb_empty", wr_q.size(), 32'd0);
    check_eq("final_idle", {28'd0, state}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
